// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage RV32I core.
// Generates stall/flush/redirect enables from execute-stage control fields.
// It also holds the pipeline during multi-cycle data-memory accesses, with a timeout.
// Optional feature macro: HAZARD_CTRL_PERF_EN enables the stall/flush performance counters.
//
// Handshake with data memory: a request is outstanding while mem_req is high.
// It completes in the cycle mem_ready is high; mem_ready in the first cycle means no stall.
module hazard_ctrl #(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_regwrite,
  input  logic [1:0]       ex_branch,
  input  logic [1:0]       ex_jump,
  input  logic             ex_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             cu_stall,
  output logic             pc_redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  // Last wait count before the timeout fires (2^TIMEOUT_W-1 wait cycles in total).
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  state_t               state, state_n;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 cnt_clr, cnt_inc, err_set;
  logic                 taken, lu_haz, mem_hold;
  logic                 sf_c, sd_c, se_c, sm_c, fd_c, fe_c, cu_c, pr_c;

  assign taken    = (ex_branch[1] & (ex_branch[0] ? ex_zero : ~ex_zero)) | ex_jump[1];
  assign lu_haz   = ex_load & ex_regwrite & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mem_hold = mem_req & ~mem_ready;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
      if (err_set)      mem_err  <= 1'b1;
    end
  end

  // Next state and raw control outputs; memory wait beats taken beats load-use.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    sf_c = 1'b0; sd_c = 1'b0; se_c = 1'b0; sm_c = 1'b0;
    fd_c = 1'b0; fe_c = 1'b0; cu_c = 1'b0; pr_c = 1'b0;
    case (state)
      MEM_WAIT: begin
        if (mem_ready) begin
          state_n = RUN;
        end else begin
          sf_c = 1'b1; sd_c = 1'b1; se_c = 1'b1; sm_c = 1'b1;
          cnt_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            // Access abandoned; pipeline proceeds with the error flagged.
            err_set = 1'b1;
            state_n = RUN;
          end
        end
      end
      default: begin
        // RUN, LU_HOLD and REDIRECT share the same priority chain; LU_HOLD skips
        // load-use (the load already left execute), REDIRECT also skips taken
        // (execute holds a bubble).
        if (mem_hold) begin
          sf_c = 1'b1; sd_c = 1'b1; se_c = 1'b1; sm_c = 1'b1;
          cnt_clr = 1'b1;
          state_n = MEM_WAIT;
        end else if (taken && state != REDIRECT) begin
          pr_c = 1'b1; fd_c = 1'b1; fe_c = 1'b1;
          state_n = REDIRECT;
        end else if (lu_haz && state == RUN) begin
          sf_c = 1'b1; sd_c = 1'b1; fe_c = 1'b1; cu_c = 1'b1;
          state_n = LU_HOLD;
        end else begin
          state_n = RUN;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign stall_f     = rst_n & sf_c;
  assign stall_d     = rst_n & sd_c;
  assign stall_e     = rst_n & se_c;
  assign stall_m     = rst_n & sm_c;
  assign flush_d     = rst_n & fd_c;
  assign flush_e     = rst_n & fe_c;
  assign cu_stall    = rst_n & cu_c;
  assign pc_redirect = rst_n & pr_c;
  assign state_dbg   = state;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Performance counters: stalled front-end cycles and redirect flushes, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_d) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (TIMEOUT_W=4) with a scoreboard and a rule-level model.
module tb_hazard_ctrl;

  localparam int TW = 4;
  localparam int CW = 32;
  localparam int W  = 9 + 2 * CW;
  localparam int TIMEOUT_CYCLES = (1 << TW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_load = 1'b0, ex_regwrite = 1'b0, ex_zero = 1'b0;
  logic [1:0] ex_branch = '0, ex_jump = '0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, cu_stall, pc_redirect, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [1:0] state_dbg;

  hazard_ctrl #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_zero(ex_zero),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .cu_stall(cu_stall),
    .pc_redirect(pc_redirect), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: what the pipeline is doing, expressed as plain flags.
  bit m_waiting = 0;        // a memory access is being waited on
  int m_waited  = 0;        // wait cycles spent after the first stalled cycle
  bit m_bubble_lu = 0;      // previous cycle inserted a load-use bubble
  bit m_bubble_br = 0;      // previous cycle redirected the PC
  bit m_err = 0;
  logic [CW-1:0] m_sc = '0, m_fc = '0;

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld, input logic rw,
                       input logic [1:0] br, input logic [1:0] jp, input logic z,
                       input logic mq, input logic mr);
    bit tk, lu, hold;
    logic [3:0] st;
    logic fd, fe, cu, pr;
    @(posedge clk); #1;
    rst_n = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_load = ld; ex_regwrite = rw;
    ex_branch = br; ex_jump = jp; ex_zero = z; mem_req = mq; mem_ready = mr;
    if (!r) begin
      m_waiting = 0; m_waited = 0; m_bubble_lu = 0; m_bubble_br = 0; m_err = 0;
      m_sc = '0; m_fc = '0;
      exp_q.push_back('0);
      return;
    end
    tk = (br[1] && (br[0] ? z : !z)) || jp[1];
    lu = ld && rw && (rd != 0) && (rd == rs1 || rd == rs2);
    hold = mq && !mr;
    st = 4'b0000; fd = 0; fe = 0; cu = 0; pr = 0;
    if (m_waiting) begin
      if (mr) begin
        m_waiting = 0;
      end else begin
        st = 4'b1111;
        m_waited++;
        if (m_waited == TIMEOUT_CYCLES) begin
          m_waiting = 0;
        end
      end
      m_bubble_lu = 0; m_bubble_br = 0;
    end else if (hold) begin
      st = 4'b1111; m_waiting = 1; m_waited = 0;
      m_bubble_lu = 0; m_bubble_br = 0;
    end else if (tk && !m_bubble_br) begin
      pr = 1; fd = 1; fe = 1;
      m_bubble_br = 1; m_bubble_lu = 0;
    end else if (lu && !m_bubble_lu && !m_bubble_br) begin
      st = 4'b1100; fe = 1; cu = 1;
      m_bubble_lu = 1; m_bubble_br = 0;
    end else begin
      m_bubble_lu = 0; m_bubble_br = 0;
    end
    // Registered outputs visible this cycle are the values before this edge.
    exp_q.push_back({st, fd, fe, cu, pr, m_err, m_sc, m_fc});
    if (st == 4'b1111 && m_waiting == 0 && !mr && m_waited == TIMEOUT_CYCLES) m_err = 1;
`ifdef HAZARD_CTRL_PERF_EN
    if (st[3]) m_sc = m_sc + 1'b1;
    if (fd)    m_fc = m_fc + 1'b1;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    idle(1);
  endtask

  task automatic rand_cycle();
    drive(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), {($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))},
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, cu_stall, pc_redirect,
           mem_err, stall_cycles, flush_count};
      checks++;
      if (a[W-1:2*CW] !== e[W-1:2*CW]) begin
        errors++;
        $display("FAIL ctrl_outputs t=%0t got=%b expected=%b (sf sd se sm fd fe cu pr err)",
                 $time, a[W-1:2*CW], e[W-1:2*CW]);
      end
      checks++;
      if (a[2*CW-1:0] !== e[2*CW-1:0]) begin
        errors++;
        $display("FAIL perf_counters t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 $time, a[2*CW-1:CW], a[CW-1:0], e[2*CW-1:CW], e[CW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CW-1:0] exp_sc, exp_fc;
    do_reset();

    // State after reset release must be RUN.
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d expected=0", state_dbg);
    end

    // Perf scenario: 1 load-use, 2 taken branches, 3-cycle memory wait.
    drive(1, 0, 5, 5, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    drive(1, 0, 5, 5, 1, 1, 2'b00, 2'b00, 0, 0, 0);   // held: no second bubble
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);   // BNE, zero=0 -> taken
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0);   // jump -> taken
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);
    idle(1);
    @(negedge clk);
`ifdef HAZARD_CTRL_PERF_EN
    exp_sc = 4; exp_fc = 2;
`else
    exp_sc = 0; exp_fc = 0;
`endif
    checks++;
    if (stall_cycles !== exp_sc || flush_count !== exp_fc) begin
      errors++;
      $display("FAIL perf_scenario got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_cycles, flush_count, exp_sc, exp_fc);
    end

    // Load-use with rd=0: no stall. BEQ with zero=0: no redirect.
    drive(1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0);
    // Wait with taken + load-use present: no flush until the wait ends.
    drive(1, 0, 5, 5, 1, 1, 2'b10, 2'b00, 0, 1, 0);
    drive(1, 0, 5, 5, 1, 1, 2'b10, 2'b00, 0, 1, 0);
    drive(1, 0, 5, 5, 1, 1, 2'b10, 2'b00, 0, 1, 1);
    drive(1, 0, 5, 5, 1, 1, 2'b10, 2'b00, 0, 0, 0);
    idle(2);
    // Zero-latency access.
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);
    idle(1);

    // Timeout: ready never comes.
    for (int i = 0; i < TIMEOUT_CYCLES + 1; i++) drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 40; i++) rand_cycle();   // mem_err must stay set
    do_reset();

    // Reset in the middle of a wait.
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    idle(1);
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL state_after_midwait_reset got=%0d expected=0", state_dbg);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) rand_cycle();
    idle(2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It watches decode/execute/memory-stage control fields and generates stage stall and flush enables. It drives the decoder's `stall` input so a squashed instruction has `RegWrite` cleared. It also holds the whole pipeline while a multi-cycle data-memory access completes, with a timeout. It sits beside the decoder and pipeline registers and owns no datapath.

## Interface
Parameters:
- `TIMEOUT_W`, 8: width of the memory-wait counter; the timeout fires after 2^TIMEOUT_W−1 wait cycles.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in decode.
- `ex_rd`  in  5  destination register of the instruction in execute.
- `ex_load`  in  1  execute instruction is a load (its `ResultSrc`).
- `ex_regwrite`  in  1  execute instruction writes the register file.
- `ex_branch`  in  2  execute branch field: MSB = is branch, LSB = 1 BEQ / 0 BNE.
- `ex_jump`  in  2  execute jump field: MSB = is jump.
- `ex_zero`  in  1  ALU zero flag of the execute instruction.
- `mem_req`  in  1  memory stage is issuing a data-memory access.
- `mem_ready`  in  1  data memory has completed the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- `flush_d`, `flush_e`  out  1 each  clear the IF-ID / ID-EX registers to a bubble.
- `cu_stall`  out  1  to the decoder `stall` input.
- `pc_redirect`  out  1  PC mux selects the branch/jump target.
- `mem_err`  out  1  sticky; a memory access timed out.
- `stall_cycles`, `flush_count`  out  CNT_W each  performance counters.

## Operation
- Derived terms:
  - `taken` = `(ex_branch[1] & (ex_branch[0] ? ex_zero : ~ex_zero)) | ex_jump[1]`.
  - `lu_haz` = `ex_load & ex_regwrite & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- FSM states: RUN, LU_HOLD, REDIRECT, MEM_WAIT.
- Priority inside RUN: memory wait, then taken, then load-use.
- RUN transitions:
  - `mem_req & ~mem_ready`: assert all four stalls, suppress flushes and `pc_redirect`, → MEM_WAIT, clear the wait counter.
  - Else `taken`: assert `pc_redirect`, `flush_d` and `flush_e`, → REDIRECT.
  - Else `lu_haz`: assert `stall_f`, `stall_d`, `flush_e` and `cu_stall`, → LU_HOLD.
  - Else: all outputs low, stay in RUN.
- LU_HOLD (1 cycle): no load-use check, because the load has already moved to MEM. Memory-wait and taken are evaluated exactly as in RUN, with the same outputs and the same next-state choices; otherwise → RUN.
- REDIRECT (1 cycle): execute holds a bubble, so no load-use check and `taken` is ignored. Memory-wait is evaluated as in RUN; otherwise → RUN.
- MEM_WAIT:
  - All four stalls stay high; the wait counter increments each cycle.
  - `mem_ready` → RUN; stalls drop in the same cycle.
  - Counter reaches 2^TIMEOUT_W−1 with no `mem_ready` → set `mem_err`, → RUN. The access is abandoned and the pipeline proceeds.
- `mem_err` clears only on reset.
- A taken branch that arrives while in MEM_WAIT is held by `stall_e`, then resolved from RUN after the wait ends.

## Timing
- All stall, flush, `pc_redirect` and `cu_stall` outputs are combinational from the current state and inputs: zero latency, same cycle as the triggering condition.
- State, the wait counter, `mem_err` and the performance counters are registered.
- Reset (`rst_n` low, at any time including mid-wait):
  - State → RUN; wait counter, `mem_err` and performance counters → 0.
  - All stall/flush/redirect/`cu_stall` outputs are forced to 0 while `rst_n` is low.
- Load-use costs exactly 1 bubble. A taken branch/jump costs 2 flushed slots, produced in 1 cycle.
- A memory access with `mem_ready` high in its first cycle costs 0 stall cycles.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined:
  - `stall_cycles` increments in every cycle where `stall_f` is high.
  - `flush_count` increments on every cycle where `flush_d` is high.
  - Both wrap modulo 2^CNT_W.
- Not defined: both counters are tied to 0 and no counter flops exist.

## Test plan
- `ex_load=1`, `ex_regwrite=1`, `ex_rd=5`, `id_rs2=5` in RUN → one cycle of `stall_f`/`stall_d`/`flush_e`/`cu_stall`, then all low the next cycle even with the inputs unchanged (LU_HOLD); same stimulus with `ex_rd=0` → no stall.
- `ex_branch=2'b10`, `ex_zero=0` → `pc_redirect`, `flush_d`, `flush_e` the same cycle; `ex_branch=2'b11`, `ex_zero=0` → no redirect; `ex_jump=2'b10` → redirect.
- `mem_req=1` with `mem_ready` low for 3 cycles then high → `stall_f`..`stall_m` high for exactly 3 cycles; a simultaneous `taken` plus `lu_haz` produces no flush until the wait ends.
- `mem_req=1`, `mem_ready` held low, `TIMEOUT_W=4` → `mem_err` sets after 15 wait cycles, stalls release, `mem_err` stays high until `rst_n` is pulsed low.
- Assert `rst_n` low in the middle of MEM_WAIT → outputs drop to 0 immediately (asynchronously), `mem_err=0`, and after release the FSM is in RUN.
- With `HAZARD_CTRL_PERF_EN`: 1 load-use + 2 taken branches + a 3-cycle memory wait → `stall_cycles=4`, `flush_count=2`; without the macro → both 0.
